// File: rtl/apb_pkg.sv
// Shared APB requester types and helpers, used by the RTL and the testbench.
package apb_pkg;

    // Requester FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_req_state_e;

    // Response codes returned on rsp_code.
    typedef enum logic [1:0] {
        RspOk      = 2'd0,
        RspSlvErr  = 2'd1,
        RspDecErr  = 2'd2,
        RspTimeout = 2'd3
    } apb_rsp_code_e;

    // Completer index = top sel_bits of an addr_width-bit byte address.
    function automatic int unsigned addr_to_idx(input logic [63:0] addr,
                                                input int unsigned addr_width,
                                                input int unsigned sel_bits);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = addr >> (addr_width - sel_bits);
        mask    = (64'd1 << sel_bits) - 64'd1;
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/apb_requester_if.sv
// Command/response channels plus the shared APB bus of the requester.
interface apb_requester_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_COMPLETERS = 4
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Command channel
    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic                                 cmd_write;
    logic [ADDR_WIDTH-1:0]                cmd_addr;
    logic [DATA_WIDTH-1:0]                cmd_wdata;
    logic [STRB_WIDTH-1:0]                cmd_strb;
    logic [2:0]                           cmd_prot;

    // Response channel
    logic                                 rsp_valid;
    logic                                 rsp_ready;
    logic [DATA_WIDTH-1:0]                rsp_rdata;
    logic                                 rsp_err;
    apb_rsp_code_e                        rsp_code;

    // APB bus
    logic [NUM_COMPLETERS-1:0]            psel;
    logic                                 penable;
    logic                                 pwrite;
    logic [ADDR_WIDTH-1:0]                paddr;
    logic [DATA_WIDTH-1:0]                pwdata;
    logic [STRB_WIDTH-1:0]                pstrb;
    logic [2:0]                           pprot;
    logic [NUM_COMPLETERS*DATA_WIDTH-1:0] prdata;
    logic [NUM_COMPLETERS-1:0]            pready;
    logic [NUM_COMPLETERS-1:0]            pslverr;

    // Requester side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_code,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    // Environment side: command source, response sink and completers
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_code,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decode: completer index, index-in-range and alignment.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_COMPLETERS = 4,
    parameter int unsigned SEL_BITS       = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [SEL_BITS-1:0]   idx,
    output logic                  hit,
    output logic                  aligned
);
    localparam int unsigned ALIGN_BITS = $clog2(DATA_WIDTH / 8);

    assign idx = SEL_BITS'(addr_to_idx(64'(addr), ADDR_WIDTH, SEL_BITS));
    assign hit = (32'(idx) < NUM_COMPLETERS);

    // Byte-wide buses have no alignment constraint.
    if (ALIGN_BITS == 0) begin : g_byte
        assign aligned = 1'b1;
    end else begin : g_wide
        assign aligned = (addr[ALIGN_BITS-1:0] == '0);
    end

endmodule

// File: rtl/apb_requester.sv
// APB requester: one outstanding command at a time, decoded onto NUM_COMPLETERS
// PSEL lines, result returned on a valid/ready response channel.
// Optional wait-state timeout enabled by defining APB_REQ_TIMEOUT_EN.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_COMPLETERS = 4,
    parameter int unsigned SEL_BITS       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          pclk,
    input  logic          preset,
    apb_requester_if.master bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    apb_req_state_e            state_q, state_d;
    logic [SEL_BITS-1:0]       idx_q, idx_d;
    logic [NUM_COMPLETERS-1:0] psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]     pstrb_q, pstrb_d;
    logic [2:0]                pprot_q, pprot_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    apb_rsp_code_e             rsp_code_q, rsp_code_d;

    logic [SEL_BITS-1:0]       dec_idx;
    logic                      dec_hit;
    logic                      dec_aligned;
    logic                      sel_ready;
    logic                      sel_err;
    logic [DATA_WIDTH-1:0]     sel_rdata;
    logic                      tmo_expire;

    apb_addr_decode #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_COMPLETERS (NUM_COMPLETERS),
        .SEL_BITS       (SEL_BITS)
    ) u_decode (
        .addr    (bus.cmd_addr),
        .idx     (dec_idx),
        .hit     (dec_hit),
        .aligned (dec_aligned)
    );

    // Only the selected completer's handshake and data are looked at.
    assign sel_ready = bus.pready[idx_q];
    assign sel_err   = bus.pslverr[idx_q];
    assign sel_rdata = bus.prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_REQ_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    // Expiry is the stalled ACCESS cycle that would bring the count to TIMEOUT_CYCLES.
    assign tmo_expire = (tmo_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Count stalled ACCESS cycles; cleared while in SETUP so each ACCESS starts at 0.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == StSetup) begin
            tmo_cnt_d = '0;
        end else if (state_q == StAccess && !sel_ready) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_expire = 1'b0;
`endif

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_code_d  = rsp_code_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (!dec_aligned || !dec_hit) begin
                        // Rejected locally; the bus is never touched.
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_code_d  = RspDecErr;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = StSetup;
                        idx_d     = dec_idx;
                        for (int i = 0; i < NUM_COMPLETERS; i++) begin
                            psel_d[i] = (SEL_BITS'(i) == dec_idx);
                        end
                        penable_d = 1'b0;
                        pwrite_d  = bus.cmd_write;
                        paddr_d   = bus.cmd_addr;
                        pwdata_d  = bus.cmd_wdata;
                        pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
                        pprot_d   = bus.cmd_prot;
                    end
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                // A pready in the expiry cycle still completes normally.
                if (sel_ready) begin
                    state_d     = StResp;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_code_d  = sel_err ? RspSlvErr : RspOk;
                    rsp_rdata_d = (sel_err || pwrite_q) ? '0 : sel_rdata;
                end else if (tmo_expire) begin
                    state_d     = StResp;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_code_d  = RspTimeout;
                    rsp_rdata_d = '0;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops psel/penable immediately.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= RspOk;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.pprot     = pprot_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_code  = rsp_code_q;

endmodule
